ring_decoder: RTL and testbench

- Receive-side companion to the generic ring counter: samples a one-hot ring state bus and reports where the hot bit is, which way it moved, and when it wrapped.
- Keeps a signed revolution count and flags illegal (non-one-hot) patterns.
- Sits on the observing end of any ring-counter-driven sequencer, such as video dot/phase rings or round-robin slot rings, to give downstream logic a binary view of the ring.

---
 rtl/ring_decoder_pkg.sv | 19 +
 rtl/ring_decoder_onehot_enc.sv | 21 ++
 rtl/ring_decoder.sv | 145 ++++++++++++++
 tb/tb_ring_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_decoder_pkg.sv
// ring_pkg: shared types and helpers for the ring decoder.
// Holds the dir_t step classification and a ring-adjacency helper.
package ring_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_JUMP  = 2'd3
  } dir_t;

  // Neighbour of position i on a ring of wid slots: left = i+1, right = i-1 (mod wid).
  function automatic int unsigned ring_adj(input int unsigned i, input int unsigned wid,
                                           input bit left);
    if (left) return (i == wid - 1) ? 0 : i + 1;
    else      return (i == 0) ? wid - 1 : i - 1;
  endfunction

endpackage

// File: rtl/ring_decoder_onehot_enc.sv
// onehot_enc: combinational one-hot to binary encoder.
// ok is high only when exactly one bit of d is set; idx is meaningful only then.
module onehot_enc #(
  parameter int WID = 8,
  localparam int IDXW = $clog2(WID)
) (
  input  logic [WID-1:0]  d,
  output logic [IDXW-1:0] idx,
  output logic            ok
);

  // OR together the positions of all set bits; exact for one-hot inputs.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WID; i++) begin
      if (d[i]) idx = idx | IDXW'(i);
    end
    ok = (d != '0) && ((d & (d - WID'(1))) == '0);
  end

endmodule

// File: rtl/ring_decoder.sv
// ring_decoder: decodes a one-hot ring state bus into position, step direction,
// wrap pulses and a signed revolution count.
// Optional feature macro: RING_DECODER_REVCNT_EN builds the revolution counter;
// without it rev is tied to zero (wrap pulses are still produced).
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WID  = 8,
  parameter int REVW = 16,
  localparam int IDXW = $clog2(WID)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            clr,
  input  logic [WID-1:0]  d,
  output logic [IDXW-1:0] idx,
  output logic            vld,
  output logic            err,
  output logic            err_sticky,
  output logic            stb,
  output logic [1:0]      dir,
  output logic            wrap_l,
  output logic            wrap_r,
  output logic [REVW-1:0] rev
);

  logic [IDXW-1:0] enc_idx;
  logic            enc_ok;
  logic            s1_pend;

  logic [IDXW-1:0] prev_idx, prev_idx_n;
  logic            prev_vld, prev_vld_n;
  dir_t            dir_q, dir_n;
  logic            stb_n, wrap_l_n, wrap_r_n;
  logic [IDXW-1:0] nb_left, nb_right;

  onehot_enc #(.WID(WID)) u_enc (
    .d   (d),
    .idx (enc_idx),
    .ok  (enc_ok)
  );

  // Stage 1: capture and classify the sample; idx keeps the last legal position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      vld        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      s1_pend    <= 1'b0;
    end else if (clr) begin
      vld        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      s1_pend    <= 1'b0;
    end else if (ce) begin
      if (enc_ok) idx <= enc_idx;
      vld        <= enc_ok;
      err        <= !enc_ok;
      err_sticky <= err_sticky | !enc_ok;
      s1_pend    <= 1'b1;
    end else begin
      err     <= 1'b0;
      s1_pend <= 1'b0;
    end
  end

  assign nb_left  = IDXW'(ring_adj(32'(prev_idx), WID, 1'b1));
  assign nb_right = IDXW'(ring_adj(32'(prev_idx), WID, 1'b0));

  // Stage 2 next-state: compare the stage-1 sample against the reference position.
  always_comb begin
    stb_n      = 1'b0;
    wrap_l_n   = 1'b0;
    wrap_r_n   = 1'b0;
    dir_n      = dir_q;
    prev_idx_n = prev_idx;
    prev_vld_n = prev_vld;
    if (clr) begin
      prev_vld_n = 1'b0;
    end else if (s1_pend) begin
      stb_n = 1'b1;
      if (!vld) begin
        dir_n      = DIR_JUMP;
        prev_vld_n = 1'b0;
      end else if (!prev_vld) begin
        dir_n      = DIR_HOLD;
        prev_vld_n = 1'b1;
        prev_idx_n = idx;
      end else if (idx == prev_idx) begin
        dir_n = DIR_HOLD;
      end else if (idx == nb_right) begin
        dir_n      = DIR_RIGHT;
        wrap_r_n   = (prev_idx == '0);
        prev_idx_n = idx;
      end else if (idx == nb_left) begin
        dir_n      = DIR_LEFT;
        wrap_l_n   = (prev_idx == IDXW'(WID - 1));
        prev_idx_n = idx;
      end else begin
        dir_n      = DIR_JUMP;
        prev_idx_n = idx;
      end
    end
  end

  // Stage 2 registers: step report pulses and the tracking reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb      <= 1'b0;
      wrap_l   <= 1'b0;
      wrap_r   <= 1'b0;
      dir_q    <= DIR_HOLD;
      prev_idx <= '0;
      prev_vld <= 1'b0;
    end else begin
      stb      <= stb_n;
      wrap_l   <= wrap_l_n;
      wrap_r   <= wrap_r_n;
      dir_q    <= dir_n;
      prev_idx <= prev_idx_n;
      prev_vld <= prev_vld_n;
    end
  end

  assign dir = dir_q;

`ifdef RING_DECODER_REVCNT_EN
  logic [REVW-1:0] rev_q;

  // Revolution counter: steps on the same edge that raises the wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rev_q <= '0;
    else if (clr)      rev_q <= '0;
    else if (wrap_l_n) rev_q <= rev_q + REVW'(1);
    else if (wrap_r_n) rev_q <= rev_q - REVW'(1);
  end

  assign rev = rev_q;
`else
  assign rev = '0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed and randomized checks of ring_decoder against a
// behavioural model of the sample/compare pipeline.
module tb_ring_decoder;

  localparam int W  = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  d = '0;
  logic [2:0]    idx;
  logic          vld, err, err_sticky, stb, wrap_l, wrap_r;
  logic [1:0]    dir;
  logic [RW-1:0] rev;

  int total = 0;
  int bad   = 0;

  // model state
  int m_idx, m_vld, m_err, m_sticky, m_pend;
  int m_stb, m_dir, m_wl, m_wr, m_pvld, m_pidx, m_rev;
  logic [W-1:0] last_ok;

  ring_decoder #(.WID(W), .REVW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d),
    .idx(idx), .vld(vld), .err(err), .err_sticky(err_sticky),
    .stb(stb), .dir(dir), .wrap_l(wrap_l), .wrap_r(wrap_r), .rev(rev)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_vld = 0; m_err = 0; m_sticky = 0; m_pend = 0;
    m_stb = 0; m_dir = 0; m_wl = 0; m_wr = 0; m_pvld = 0; m_pidx = 0; m_rev = 0;
  endtask

  // One clock edge of the specified behaviour, given the inputs seen at that edge.
  task automatic model_edge(input logic c, input logic cl, input logic [W-1:0] dv);
    int pos;
    if (cl) begin
      m_pend = 0; m_vld = 0; m_err = 0; m_sticky = 0;
      m_pvld = 0; m_rev = 0; m_stb = 0; m_wl = 0; m_wr = 0;
      return;
    end
    m_wl = 0; m_wr = 0; m_stb = m_pend;
    if (m_pend) begin
      if (m_vld == 0) begin
        m_dir = 3; m_pvld = 0;
      end else if (m_pvld == 0) begin
        m_dir = 0; m_pvld = 1; m_pidx = m_idx;
      end else if (m_idx == m_pidx) begin
        m_dir = 0;
      end else if (m_idx == (m_pidx + W - 1) % W) begin
        m_dir = 1; m_wr = (m_pidx == 0); m_pidx = m_idx;
      end else if (m_idx == (m_pidx + 1) % W) begin
        m_dir = 2; m_wl = (m_pidx == W - 1); m_pidx = m_idx;
      end else begin
        m_dir = 3; m_pidx = m_idx;
      end
      m_rev = (m_rev + m_wl - m_wr) & ((1 << RW) - 1);
    end
    if (c) begin
      pos = 0;
      for (int i = 0; i < W; i++) if (dv[i]) pos = i;
      m_vld = ($countones(dv) == 1);
      if (m_vld != 0) m_idx = pos;
      m_err = !m_vld;
      m_sticky = m_sticky | m_err;
      m_pend = 1;
    end else begin
      m_err = 0; m_pend = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_rev;
`ifdef RING_DECODER_REVCNT_EN
    exp_rev = m_rev;
`else
    exp_rev = 0;
`endif
    check({tag, ".idx"}, idx, m_idx);
    check({tag, ".vld"}, vld, m_vld);
    check({tag, ".err"}, err, m_err);
    check({tag, ".err_sticky"}, err_sticky, m_sticky);
    check({tag, ".stb"}, stb, m_stb);
    check({tag, ".dir"}, dir, m_dir);
    check({tag, ".wrap_l"}, wrap_l, m_wl);
    check({tag, ".wrap_r"}, wrap_r, m_wr);
    check({tag, ".rev"}, rev, exp_rev);
  endtask

  task automatic step(input string tag, input logic c, input logic cl, input logic [W-1:0] dv);
    ce = c; clr = cl; d = dv;
    @(posedge clk);
    model_edge(c, cl, dv);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] v;
    int r;
    model_reset();
    last_ok = 8'h80;
    #1;
    check_all("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first sample after reset: resync, HOLD
    step("first", 1'b1, 1'b0, 8'h80);
    step("first_s2", 1'b0, 1'b0, 8'h00);
    step("first_idle", 1'b0, 1'b0, 8'h00);

    // right shifts round the ring, wrap_r on 01->80
    v = 8'h80;
    for (int i = 0; i < 9; i++) begin
      step("right", 1'b1, 1'b0, v);
      v = {v[0], v[W-1:1]};
    end
    step("right_tail", 1'b0, 1'b0, 8'h00);
    step("right_tail2", 1'b0, 1'b0, 8'h00);

    // left shifts twice round, after a clear
    step("clr_a", 1'b0, 1'b1, 8'h00);
    v = 8'h01;
    for (int i = 0; i < 17; i++) begin
      step("left", 1'b1, 1'b0, v);
      v = {v[W-2:0], v[W-1]};
    end
    step("left_tail", 1'b0, 1'b0, 8'h00);
    step("left_tail2", 1'b0, 1'b0, 8'h00);

    // illegal patterns then resync, then clear
    step("zero", 1'b1, 1'b0, 8'h00);
    step("multi", 1'b1, 1'b0, 8'h18);
    step("resync", 1'b1, 1'b0, 8'h04);
    step("err_tail", 1'b0, 1'b0, 8'h00);
    step("err_tail2", 1'b0, 1'b0, 8'h00);
    step("clr_b", 1'b0, 1'b1, 8'h00);

    // jump, then ce toggling
    step("jmp_a", 1'b1, 1'b0, 8'h01);
    step("jmp_b", 1'b1, 1'b0, 8'h10);
    for (int i = 0; i < 8; i++) step("toggle", (i % 2) == 0, 1'b0, 8'h20);
    step("tog_tail", 1'b0, 1'b0, 8'h00);

    // clr with ce while a sample sits in stage 1
    step("pre_clr", 1'b1, 1'b0, 8'h08);
    step("clr_ce", 1'b1, 1'b1, 8'h02);
    step("post_clr", 1'b0, 1'b0, 8'h00);
    step("post_clr2", 1'b0, 1'b0, 8'h00);

    // reset mid-stream drops in-flight samples
    step("pre_rst", 1'b1, 1'b0, 8'h40);
    step("pre_rst2", 1'b1, 1'b0, 8'h20);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 1'b1, 1'b0, 8'h02);
    step("after_rst2", 1'b1, 1'b0, 8'h04);
    step("after_rst3", 1'b0, 1'b0, 8'h00);

    // randomized walk: mostly legal moves with occasional junk and clears
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      v = {last_ok[0], last_ok[W-1:1]};
      else if (r < 60) v = {last_ok[W-2:0], last_ok[W-1]};
      else if (r < 70) v = last_ok;
      else if (r < 85) v = 8'h01 << $urandom_range(0, W - 1);
      else             v = 8'($urandom);
      if ($countones(v) == 1) last_ok = v;
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, v);
    end
    step("rand_tail", 1'b0, 1'b0, 8'h00);
    step("rand_tail2", 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
